sys_ctrl_tx_seq: RTL and testbench
==================================

# sys_ctrl_tx_seq

Transmit-side sequencer of the system controller, successor to the single-byte Tx control. It accepts register-file read data and ALU results and queues them in a small FIFO. Each queued response is split into WIDTH-bit bytes and handed to the UART transmitter one byte at a time, using a toggle-valid handshake for the fast-to-slow crossing. ALU result width, queue depth and the Busy-rise timeout are parameters.

## Interface
- WIDTH, 8, byte width of the UART payload
- RES_BYTES, 2, bytes in a full ALU result (≥1)
- FIFO_DEPTH, 4, queued responses (power of 2, ≥2)
- BUSY_TO, 16, cycles to wait for Busy to rise before the byte is treated as taken

- CLK  in  1  single clock
- Reset  in  1  synchronous, active-high reset
- RdData  in  WIDTH  register-file read data
- Rd_valid  in  1  RdData valid, 1-cycle pulse
- ALU_out  in  RES_BYTES*WIDTH  ALU result
- ALU_out_valid  in  1  ALU_out valid, 1-cycle pulse
- ALU_FUN  in  4  ALU opcode accompanying ALU_out
- Busy  in  1  transmitter busy, already synchronised to CLK
- Tx_Data  out  WIDTH  byte to transmit
- Tx_Data_valid  out  1  toggles once per new byte
- Tx_Idle  out  1  FSM in IDLE and FIFO empty
- Overflow  out  1  1-cycle pulse: response dropped because the FIFO is full
- Collision  out  1  1-cycle pulse: ALU response dropped because Rd_valid was asserted in the same cycle

## Operation
- Enqueue:
  - Rd_valid=1: entry {data=RdData zero-extended, count=1}.
  - Else ALU_out_valid=1: count=RES_BYTES when ALU_FUN[3:2]==2'b00 (arithmetic), otherwise count=1 (low byte only). Data is ALU_out.
  - Both asserted in the same cycle: the Rd entry is written, the ALU entry is dropped, and Collision pulses.
  - FIFO full: the entry is dropped and Overflow pulses. A simultaneous pop does not make room in that cycle.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE with FIFO non-empty: pop the entry into the shift register and the remaining-byte counter, drive the low byte onto Tx_Data, toggle Tx_Data_valid, go to WAIT_HI.
  - WAIT_HI: Busy=1 → WAIT_LO. If the timeout counter reaches BUSY_TO, go to WAIT_LO (the byte is treated as taken).
  - WAIT_LO: on Busy=0, if bytes remain, shift right by WIDTH, drive the next byte, toggle, and go to WAIT_HI. Otherwise go to IDLE.
- Bytes go out LSB first.
- Tx_Data changes only on the edge where Tx_Data_valid toggles, and holds otherwise.
- Reset values: Tx_Data=0, Tx_Data_valid=0, Tx_Idle=1, Overflow=0, Collision=0, FIFO empty, state IDLE, counters 0.
- Reset mid-frame: remaining bytes and queued entries are discarded. If Tx_Data_valid was 1, the reset produces one toggle that the receiving side must tolerate; this is documented system behaviour.

## Timing
- Input sampled at edge E0 (written into the FIFO).
- With IDLE and an empty FIFO, the first byte appears and Tx_Data_valid toggles at E1: 1-cycle latency.
- Next byte: toggles on the edge after the cycle where Busy=0 is sampled in WAIT_LO.
- IDLE lasts at least one cycle between responses.
- Busy-rise timeout: WAIT_LO is entered at the BUSY_TO-th edge spent in WAIT_HI.
- Overflow and Collision are registered: they assert at E1 for an input sampled at E0.
- Tx_Idle is registered and deasserts at E1 after any accepted enqueue.

## Structure
- Shared package sys_ctrl_pkg holds:
  - state encoding;
  - ALU class constants (ALU_ARITH = 2'b00 on ALU_FUN[3:2]);
  - an entry-width helper: RES_BYTES*WIDTH + $clog2(RES_BYTES+1).
- One sub-module, sync_fifo (parametrised data width and depth, full/empty flags, synchronous active-high reset), instantiated once.
- The FSM, shift register and timeout counter live in the top.

## Test plan
- Rd_valid with RdData=8'hA5, Busy held idle-high pattern (rises at 2 cycles, falls at 10) → Tx_Data=8'hA5 at E1, one toggle, Tx_Idle returns to 1.
- ALU_out=16'h1234, ALU_FUN=4'b0001 → toggles with 8'h34 then 8'h12. The second toggle occurs only after Busy goes 1 then 0.
- ALU_out=16'h1234, ALU_FUN=4'b1010 → a single toggle with 8'h34.
- Rd_valid and ALU_out_valid in the same cycle → only RdData is sent and Collision pulses for 1 cycle. Then 5 back-to-back Rd pulses with Busy stuck at 1 → the 5th produces Overflow and the first 4 are sent in order.
- Busy stuck at 0 → each byte advances after BUSY_TO+1 cycles. Reset asserted between the two bytes of a 2-byte result → outputs return to reset values next edge and no second byte is sent.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-controller transmit path.
package sys_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } tx_state_e;

    // ALU_FUN[3:2] class code for arithmetic ops, which return a full-width result
    localparam logic [1:0] ALU_ARITH = 2'b00;

    // Queue entry: payload plus remaining-byte count
    function automatic int entry_width(input int res_bytes, input int width);
        return res_bytes * width + $clog2(res_bytes + 1);
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_seq_fifo.sv
// Single-clock FIFO; head word is visible on rdata while not empty.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/sys_ctrl_tx_seq.sv
// Transmit sequencer: queues Rd/ALU responses and feeds them to the UART
// one byte at a time, LSB first, with a toggle-valid handshake.
module sys_ctrl_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RES_BYTES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_TO    = 16
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           RdData,
    input  logic                       Rd_valid,
    input  logic [RES_BYTES*WIDTH-1:0] ALU_out,
    input  logic                       ALU_out_valid,
    input  logic [3:0]                 ALU_FUN,
    input  logic                       Busy,
    output logic [WIDTH-1:0]           Tx_Data,
    output logic                       Tx_Data_valid,
    output logic                       Tx_Idle,
    output logic                       Overflow,
    output logic                       Collision
);
    localparam int DW = RES_BYTES * WIDTH;
    localparam int CW = $clog2(RES_BYTES + 1);
    localparam int EW = entry_width(RES_BYTES, WIDTH);
    localparam int TW = $clog2(BUSY_TO + 1);

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        enq, head;
    logic [EW-1:0] head_raw;
    logic          enq_req, push, pop, full, empty;
    logic          drop_ovf, drop_col;
    tx_state_e     state, state_n;
    logic [DW-1:0] shreg, shifted;
    logic [CW-1:0] rem;
    logic [TW-1:0] tmo;
    logic          load, advance, tmo_inc;
    logic          unused_fun;

    assign unused_fun = ^ALU_FUN[1:0];

    // Rd wins over ALU; a simultaneous ALU result is dropped
    always_comb begin
        enq = '0;
        if (Rd_valid) begin
            enq.data = DW'(RdData);
            enq.cnt  = CW'(1);
        end else begin
            enq.data = ALU_out;
            enq.cnt  = (ALU_FUN[3:2] == ALU_ARITH) ? CW'(RES_BYTES) : CW'(1);
        end
    end

    assign enq_req = Rd_valid || ALU_out_valid;
    assign push    = enq_req && !full;
    assign head    = entry_t'(head_raw);
    assign shifted = shreg >> WIDTH;

    sync_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .Reset (Reset),
        .push  (push),
        .wdata (EW'(enq)),
        .pop   (pop),
        .rdata (head_raw),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        tmo_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // No Busy rise within BUSY_TO edges: assume the byte was taken
                if (Busy || tmo == TW'(BUSY_TO - 1)) state_n = WAIT_LO;
                else                                 tmo_inc = 1'b1;
            end
            WAIT_LO: begin
                if (!Busy) begin
                    if (rem != '0) begin
                        advance = 1'b1;
                        state_n = WAIT_HI;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            shreg         <= '0;
            rem           <= '0;
            tmo           <= '0;
            Tx_Data       <= '0;
            Tx_Data_valid <= 1'b0;
            Tx_Idle       <= 1'b1;
            drop_ovf      <= 1'b0;
            drop_col      <= 1'b0;
            Overflow      <= 1'b0;
            Collision     <= 1'b0;
        end else begin
            // Drop flags pass through one extra stage to line up with the first-byte edge
            drop_ovf  <= enq_req && full;
            drop_col  <= Rd_valid && ALU_out_valid;
            Overflow  <= drop_ovf;
            Collision <= drop_col;
            Tx_Idle   <= (state_n == IDLE) && empty;
            tmo       <= tmo_inc ? tmo + TW'(1) : '0;
            if (load) begin
                shreg         <= head.data;
                rem           <= head.cnt - CW'(1);
                Tx_Data       <= head.data[WIDTH-1:0];
                Tx_Data_valid <= ~Tx_Data_valid;
            end else if (advance) begin
                shreg         <= shifted;
                rem           <= rem - CW'(1);
                Tx_Data       <= shifted[WIDTH-1:0];
                Tx_Data_valid <= ~Tx_Data_valid;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_tx_seq.sv
// Bench for sys_ctrl_tx_seq: directed scenarios plus randomized traffic
// checked against a queue-level model of the byte stream.
module tb_sys_ctrl_tx_seq;
    localparam int WIDTH      = 8;
    localparam int RES_BYTES  = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int BUSY_TO    = 16;

    logic                       CLK = 1'b0;
    logic                       Reset = 1'b1;
    logic [WIDTH-1:0]           RdData = '0;
    logic                       Rd_valid = 1'b0;
    logic [RES_BYTES*WIDTH-1:0] ALU_out = '0;
    logic                       ALU_out_valid = 1'b0;
    logic [3:0]                 ALU_FUN = '0;
    logic                       Busy = 1'b0;
    logic [WIDTH-1:0]           Tx_Data;
    logic                       Tx_Data_valid, Tx_Idle, Overflow, Collision;

    int   nvec = 0, nerr = 0;
    logic prev_vld = 1'b0;
    bit   tog;

    sys_ctrl_tx_seq #(.WIDTH(WIDTH), .RES_BYTES(RES_BYTES), .FIFO_DEPTH(FIFO_DEPTH), .BUSY_TO(BUSY_TO)) dut (
        .CLK(CLK), .Reset(Reset), .RdData(RdData), .Rd_valid(Rd_valid),
        .ALU_out(ALU_out), .ALU_out_valid(ALU_out_valid), .ALU_FUN(ALU_FUN), .Busy(Busy),
        .Tx_Data(Tx_Data), .Tx_Data_valid(Tx_Data_valid), .Tx_Idle(Tx_Idle),
        .Overflow(Overflow), .Collision(Collision)
    );

    always #5 CLK = ~CLK;

    // Advance one edge, sample 1 time unit later, note whether valid toggled
    task automatic step();
        @(posedge CLK);
        #1;
        tog      = (Tx_Data_valid !== prev_vld);
        prev_vld = Tx_Data_valid;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(); step();
        nvec++; if (Tx_Data !== 8'h00)     begin nerr++; $display("FAIL reset_tx_data got %h want 00", Tx_Data); end
        nvec++; if (Tx_Data_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", Tx_Data_valid); end
        nvec++; if (Tx_Idle !== 1'b1)       begin nerr++; $display("FAIL reset_idle got %b want 1", Tx_Idle); end
        nvec++; if (Overflow !== 1'b0)      begin nerr++; $display("FAIL reset_ovf got %b want 0", Overflow); end
        nvec++; if (Collision !== 1'b0)     begin nerr++; $display("FAIL reset_col got %b want 0", Collision); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_rd_single();
        int ntog = 0;
        Busy = 1'b0; RdData = 8'hA5; Rd_valid = 1'b1;
        step();
        Rd_valid = 1'b0;
        nvec++; if (tog !== 1'b0)    begin nerr++; $display("FAIL rd_e0_toggle got %b want 0", tog); end
        nvec++; if (Tx_Idle !== 1'b1) begin nerr++; $display("FAIL rd_e0_idle got %b want 1", Tx_Idle); end
        step();
        nvec++; if (tog !== 1'b1)      begin nerr++; $display("FAIL rd_e1_toggle got %b want 1", tog); end
        nvec++; if (Tx_Data !== 8'hA5) begin nerr++; $display("FAIL rd_e1_data got %h want a5", Tx_Data); end
        nvec++; if (Tx_Idle !== 1'b0)  begin nerr++; $display("FAIL rd_e1_idle got %b want 0", Tx_Idle); end
        step(); ntog += tog;
        Busy = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); ntog += tog; end
        Busy = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); ntog += tog; end
        nvec++; if (ntog != 0)         begin nerr++; $display("FAIL rd_extra_toggles got %0d want 0", ntog); end
        nvec++; if (Tx_Data !== 8'hA5) begin nerr++; $display("FAIL rd_hold got %h want a5", Tx_Data); end
        nvec++; if (Tx_Idle !== 1'b1)  begin nerr++; $display("FAIL rd_idle_back got %b want 1", Tx_Idle); end
    endtask

    task automatic test_alu_arith();
        int ntog = 0;
        ALU_out = 16'h1234; ALU_FUN = 4'b0001; ALU_out_valid = 1'b1;
        step();
        ALU_out_valid = 1'b0;
        step();
        nvec++; if (tog !== 1'b1 || Tx_Data !== 8'h34) begin nerr++; $display("FAIL arith_byte0 got tog=%b %h want tog=1 34", tog, Tx_Data); end
        for (int i = 0; i < 3; i++) begin step(); ntog += tog; end
        Busy = 1'b1;
        for (int i = 0; i < 4; i++) begin step(); ntog += tog; end
        nvec++; if (ntog != 0) begin nerr++; $display("FAIL arith_early_toggle got %0d want 0", ntog); end
        Busy = 1'b0;
        step();
        nvec++; if (tog !== 1'b1 || Tx_Data !== 8'h12) begin nerr++; $display("FAIL arith_byte1 got tog=%b %h want tog=1 12", tog, Tx_Data); end
        Busy = 1'b1; step(); step();
        Busy = 1'b0; step(); step(); step();
        nvec++; if (Tx_Idle !== 1'b1) begin nerr++; $display("FAIL arith_idle got %b want 1", Tx_Idle); end
    endtask

    task automatic test_alu_logic();
        int ntog = 0;
        ALU_out = 16'h1234; ALU_FUN = 4'b1010; ALU_out_valid = 1'b1;
        step();
        ALU_out_valid = 1'b0;
        step();
        nvec++; if (tog !== 1'b1 || Tx_Data !== 8'h34) begin nerr++; $display("FAIL logic_byte0 got tog=%b %h want tog=1 34", tog, Tx_Data); end
        Busy = 1'b1; step(); step();
        Busy = 1'b0;
        for (int i = 0; i < 25; i++) begin step(); ntog += tog; end
        nvec++; if (ntog != 0)        begin nerr++; $display("FAIL logic_extra_toggles got %0d want 0", ntog); end
        nvec++; if (Tx_Idle !== 1'b1) begin nerr++; $display("FAIL logic_idle got %b want 1", Tx_Idle); end
    endtask

    task automatic test_collision_overflow();
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int bc = 0;
        Busy = 1'b0;
        RdData = 8'h5A; Rd_valid = 1'b1; ALU_out = 16'hBEEF; ALU_FUN = 4'b0000; ALU_out_valid = 1'b1;
        step();
        Rd_valid = 1'b0; ALU_out_valid = 1'b0;
        nvec++; if (Collision !== 1'b0) begin nerr++; $display("FAIL col_e0 got %b want 0", Collision); end
        step();
        nvec++; if (Collision !== 1'b1) begin nerr++; $display("FAIL col_e1 got %b want 1", Collision); end
        nvec++; if (tog !== 1'b1 || Tx_Data !== 8'h5A) begin nerr++; $display("FAIL col_data got tog=%b %h want tog=1 5a", tog, Tx_Data); end
        step();
        nvec++; if (Collision !== 1'b0) begin nerr++; $display("FAIL col_pulse_width got %b want 0", Collision); end
        Busy = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            RdData = 8'((i + 1) * 8'h11); Rd_valid = 1'b1;
            step();
            nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_early idx=%0d got %b want 0", i, Overflow); end
        end
        Rd_valid = 1'b0;
        step();
        nvec++; if (Overflow !== 1'b1) begin nerr++; $display("FAIL ovf_pulse got %b want 1", Overflow); end
        step();
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_pulse_width got %b want 0", Overflow); end
        Busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tog) begin got.push_back(Tx_Data); bc = 4; end
            if (bc > 0) bc--;
            Busy = (bc == 3 || bc == 2);
        end
        nvec++; if (got.size() != 4) begin nerr++; $display("FAIL ovf_sent_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            nvec++; if (got[i] !== want[i]) begin nerr++; $display("FAIL ovf_order idx=%0d got %h want %h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_timeout_reset();
        logic [15:0] v, w;
        int n = 0, ntog = 0;
        Busy = 1'b0;
        v = 16'($urandom); ALU_out = v; ALU_FUN = {2'b00, 2'($urandom)}; ALU_out_valid = 1'b1;
        step();
        ALU_out_valid = 1'b0;
        step();
        nvec++; if (tog !== 1'b1 || Tx_Data !== v[7:0]) begin nerr++; $display("FAIL to_byte0 got tog=%b %h want tog=1 %h", tog, Tx_Data, v[7:0]); end
        for (int i = 1; i <= 40; i++) begin
            step();
            if (tog) begin n = i; break; end
        end
        nvec++; if (n != BUSY_TO + 1)     begin nerr++; $display("FAIL to_gap got %0d want %0d", n, BUSY_TO + 1); end
        nvec++; if (Tx_Data !== v[15:8]) begin nerr++; $display("FAIL to_byte1 got %h want %h", Tx_Data, v[15:8]); end
        for (int i = 0; i < 40; i++) step();
        nvec++; if (Tx_Idle !== 1'b1) begin nerr++; $display("FAIL to_idle got %b want 1", Tx_Idle); end

        w = 16'($urandom); ALU_out = w; ALU_FUN = 4'b0011; ALU_out_valid = 1'b1;
        step();
        ALU_out_valid = 1'b0;
        step();
        nvec++; if (tog !== 1'b1 || Tx_Data !== w[7:0]) begin nerr++; $display("FAIL rst_byte0 got tog=%b %h want tog=1 %h", tog, Tx_Data, w[7:0]); end
        RdData = 8'hC3; Rd_valid = 1'b1; step();
        Rd_valid = 1'b0; step(); step();
        Reset = 1'b1;
        step();
        nvec++; if (Tx_Data !== 8'h00 || Tx_Data_valid !== 1'b0 || Tx_Idle !== 1'b1)
            begin nerr++; $display("FAIL rst_mid got %h/%b/%b want 00/0/1", Tx_Data, Tx_Data_valid, Tx_Idle); end
        Reset = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); ntog += tog; end
        nvec++; if (ntog != 0) begin nerr++; $display("FAIL rst_discard got %0d toggles want 0", ntog); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_q[$];
        int               resp_q[$];
        int               occ = 0, cur_left = 0, rise = -1, hold = 0;
        logic             exp_ovf = 1'b0, exp_col = 1'b0;
        logic [WIDTH-1:0] last_tx, rd;
        logic [15:0]      alu;
        logic [3:0]       fun;
        bit               rv, av;
        last_tx = Tx_Data;
        Busy = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            rv  = (cyc < 500) && ($urandom_range(0, 4) == 0);
            av  = (cyc < 500) && ($urandom_range(0, 4) == 0);
            rd  = 8'($urandom); alu = 16'($urandom); fun = 4'($urandom);
            RdData = rd; Rd_valid = rv; ALU_out = alu; ALU_out_valid = av; ALU_FUN = fun;
            step();
            nvec++; if (Overflow !== exp_ovf)  begin nerr++; $display("FAIL rnd_ovf cyc=%0d got %b want %b", cyc, Overflow, exp_ovf); end
            nvec++; if (Collision !== exp_col) begin nerr++; $display("FAIL rnd_col cyc=%0d got %b want %b", cyc, Collision, exp_col); end
            // Acceptance uses occupancy before this edge's pop
            exp_col = rv && av;
            exp_ovf = (rv || av) && (occ == FIFO_DEPTH);
            if ((rv || av) && occ < FIFO_DEPTH) begin
                occ++;
                if (rv) begin exp_q.push_back(rd); resp_q.push_back(1); end
                else if (fun[3:2] == 2'b00) begin exp_q.push_back(alu[7:0]); exp_q.push_back(alu[15:8]); resp_q.push_back(2); end
                else begin exp_q.push_back(alu[7:0]); resp_q.push_back(1); end
            end
            if (tog) begin
                if (cur_left == 0) begin
                    if (resp_q.size() > 0) begin cur_left = resp_q.pop_front(); occ--; end
                    else cur_left = 1;
                end
                cur_left--;
                nvec++; if (exp_q.size() == 0 || Tx_Data !== exp_q[0])
                    begin nerr++; $display("FAIL rnd_byte cyc=%0d got %h want %h", cyc, Tx_Data, (exp_q.size() > 0) ? exp_q[0] : 8'h00); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                last_tx = Tx_Data;
                rise = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 2));
                hold = $urandom_range(1, 4);
            end else begin
                nvec++; if (Tx_Data !== last_tx) begin nerr++; $display("FAIL rnd_hold cyc=%0d got %h want %h", cyc, Tx_Data, last_tx); end
            end
            if (rise == 0) begin Busy = 1'b1; rise = -1; end
            else if (rise > 0) rise--;
            else if (Busy) begin if (hold == 0) Busy = 1'b0; else hold--; end
        end
        nvec++; if (exp_q.size() != 0) begin nerr++; $display("FAIL rnd_drain got %0d bytes left want 0", exp_q.size()); end
        nvec++; if (Tx_Idle !== 1'b1)  begin nerr++; $display("FAIL rnd_idle got %b want 1", Tx_Idle); end
    endtask

    initial begin
        test_reset();
        test_rd_single();
        test_alu_arith();
        test_alu_logic();
        test_collision_overflow();
        test_timeout_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
